// File: rtl/mem_block_ctrl.sv
// mem_block_ctrl: line-fill / write-back memory controller moving one cache line word by word with fixed latency.
// Optional MEM_CRITICAL_WORD_FIRST_EN: reads start at the requested word offset and wrap.
module mem_block_ctrl #(
  parameter int c_line_size    = 32,
  parameter int c_block_size   = 2,
  parameter int mem_addr_width = 6,
  parameter int word_latency   = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   m_read_i,
  input  logic                                   m_wr_i,
  input  logic [c_line_size-1:0]                 m_address_i,
  input  logic [c_line_size*2**c_block_size-1:0] m_wdata_i,
  output logic [c_line_size*2**c_block_size-1:0] m_rdata_o,
  output logic [2**c_block_size-1:0]             m_rvalid_o,
  output logic                                   m_busywait_o
);
  localparam int n_words = 2**c_block_size;
  localparam int lw = word_latency > 1 ? $clog2(word_latency) : 1;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state;
  logic [c_line_size-1:0] mem [2**(mem_addr_width+c_block_size)];
  logic [n_words-1:0][c_line_size-1:0] wbuf, rdata;
  logic [mem_addr_width-1:0] idx;
  logic [c_block_size-1:0] cnt, start, slot;
  logic [lw-1:0] lat;
  logic tick, last, unused_addr;
  assign slot = cnt + start;
  assign tick = lat == lw'(word_latency - 1);
  assign last = cnt == {c_block_size{1'b1}};
  assign m_rdata_o = rdata;
  assign m_busywait_o = state == IDLE ? (m_read_i | m_wr_i) : state != DONE;
  assign unused_addr = ^m_address_i;
  // Storage has no reset: committed words survive an aborted write.
  always_ff @(posedge clk_i)
    if (state == WRITE && tick) mem[{idx, slot}] <= wbuf[slot];
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state      <= IDLE;
      cnt        <= '0;
      lat        <= '0;
      idx        <= '0;
      start      <= '0;
      wbuf       <= '0;
      rdata      <= '0;
      m_rvalid_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          lat <= '0;
          idx <= m_address_i[mem_addr_width+c_block_size+1:c_block_size+2];
          if (m_read_i) begin
            state      <= READ;
            m_rvalid_o <= '0;
`ifdef MEM_CRITICAL_WORD_FIRST_EN
            start      <= m_address_i[c_block_size+1:2];
`else
            start      <= '0;
`endif
          end else if (m_wr_i) begin
            state <= WRITE;
            start <= '0;
            wbuf  <= m_wdata_i;
          end
        end
        READ, WRITE: begin
          lat <= tick ? '0 : lat + lw'(1);
          if (tick) begin
            if (state == READ) begin
              rdata[slot]      <= mem[{idx, slot}];
              m_rvalid_o[slot] <= 1'b1;
            end
            cnt <= cnt + 1'b1;
            if (last) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_block_ctrl.sv
// tb_mem_block_ctrl: table-driven line transfers on a latency-4 instance plus per-edge checks on a latency-1 instance.
module tb_mem_block_ctrl;
  typedef struct {
    bit rd;
    bit wr;
    logic [31:0] addr;
    logic [127:0] wdata;
    logic [127:0] erd;
    logic [3:0] ev;
    int ecyc;
  } vec_t;
  logic clk = 0, reset = 1;
  logic rd [2], wr [2], busy [2];
  logic [31:0] addr [2];
  logic [127:0] wdata [2], rdata [2];
  logic [3:0] rvalid [2];
  int n_tests = 0, n_fail = 0, cyc;
  vec_t vecs [8];
  localparam logic [127:0] la = 128'h00000044_00000033_00000022_00000011;
  localparam logic [127:0] lb = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [127:0] lc = 128'h0B000004_0B000003_0B000002_0B000001;
  localparam logic [127:0] lw = 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978;
  always #5 clk = ~clk;
  mem_block_ctrl #(.word_latency(4)) u0 (
    .clk_i(clk), .reset_i(reset), .m_read_i(rd[0]), .m_wr_i(wr[0]), .m_address_i(addr[0]),
    .m_wdata_i(wdata[0]), .m_rdata_o(rdata[0]), .m_rvalid_o(rvalid[0]), .m_busywait_o(busy[0]));
  mem_block_ctrl #(.word_latency(1)) u1 (
    .clk_i(clk), .reset_i(reset), .m_read_i(rd[1]), .m_wr_i(wr[1]), .m_address_i(addr[1]),
    .m_wdata_i(wdata[1]), .m_rdata_o(rdata[1]), .m_rvalid_o(rvalid[1]), .m_busywait_o(busy[1]));
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic xact(input int s, input bit r, input bit w, input logic [31:0] a,
                      input logic [127:0] d, output int c);
    @(negedge clk);
    rd[s] = r; wr[s] = w; addr[s] = a; wdata[s] = d;
    #1 chk("req_busy", 128'(busy[s]), 128'd1);
    @(posedge clk);
    c = 0;
    while (c < 100) begin
      @(negedge clk);
      if (!busy[s]) break;
      c++;
    end
    rd[s] = 0; wr[s] = 0;
    @(posedge clk);
  endtask
  task automatic stepped(input logic [31:0] a, input logic [15:0] em, input logic [127:0] ed);
    @(negedge clk);
    rd[1] = 1; addr[1] = a;
    @(posedge clk);
    @(negedge clk);
    chk("rv_clear", 128'(rvalid[1]), 128'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rv_step", 128'(rvalid[1]), 128'(em[k*4+:4]));
    end
    chk("l1_done_busy", 128'(busy[1]), 128'd0);
    chk("l1_rdata", rdata[1], ed);
    rd[1] = 0;
    @(posedge clk);
  endtask
  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h40,  la, 128'd0, 4'h0, 16};
    vecs[1] = '{1'b1, 1'b0, 32'h40,  128'd0, la, 4'hF, 16};
    vecs[2] = '{1'b0, 1'b1, 32'h80,  lb, 128'd0, 4'h0, 16};
    vecs[3] = '{1'b1, 1'b1, 32'h80,  {4{32'hFFFFFFFF}}, lb, 4'hF, 16};
    vecs[4] = '{1'b1, 1'b0, 32'h80,  128'd0, lb, 4'hF, 16};
    vecs[5] = '{1'b0, 1'b1, 32'h10,  lc, 128'd0, 4'h0, 16};
    vecs[6] = '{1'b1, 1'b0, 32'h410, 128'd0, lc, 4'hF, 16};
    vecs[7] = '{1'b0, 1'b1, 32'h20,  128'd0, 128'd0, 4'h0, 16};
    for (int s = 0; s < 2; s++) begin
      rd[s] = 0; wr[s] = 0; addr[s] = 0; wdata[s] = 0;
    end
    #12;
    chk("rst_busy", 128'(busy[0]), 128'd0);
    chk("rst_rdata", rdata[0], 128'd0);
    chk("rst_rvalid", 128'(rvalid[0]), 128'd0);
    @(negedge clk) reset = 0;
    foreach (vecs[i]) begin
      xact(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, cyc);
      chk("busy_cycles", 128'(cyc), 128'(vecs[i].ecyc));
      if (vecs[i].rd) begin
        chk("rdata", rdata[0], vecs[i].erd);
        chk("rvalid", 128'(rvalid[0]), 128'(vecs[i].ev));
      end
    end
    // Abort a write after word 0 (edge E0+4) but before word 1 (edge E0+8).
    @(negedge clk);
    wr[0] = 1; addr[0] = 32'h20;
    wdata[0] = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1 wr[0] = 0; reset = 1;
    #1;
    chk("abort_busy", 128'(busy[0]), 128'd0);
    chk("abort_rdata", rdata[0], 128'd0);
    chk("abort_rvalid", 128'(rvalid[0]), 128'd0);
    @(negedge clk) reset = 0;
    xact(0, 1, 0, 32'h20, 128'd0, cyc);
    chk("abort_reread", rdata[0], {96'd0, 32'hAAAA0001});
    xact(1, 0, 1, 32'h40, lw, cyc);
    chk("l1_wr_cycles", 128'(cyc), 128'd4);
    xact(1, 1, 0, 32'h40, 128'd0, cyc);
    chk("l1_rd_cycles", 128'(cyc), 128'd4);
    stepped(32'h40, 16'hF731, lw);
`ifdef MEM_CRITICAL_WORD_FIRST_EN
    stepped(32'h4C, 16'hFB98, lw);
`else
    stepped(32'h4C, 16'hF731, lw);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
